// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the decode/issue controller:
//   - RV32 major opcode constants (inst[6:2])
//   - immediate-format enum (R=0 I=1 S=2 B=3 U=4 J=5)
//   - controller state enum (RUN, TRAP)
//   - decoded FIFO entry record
// -----------------------------------------------------------------------------
package decode_pkg;

    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    typedef enum logic [2:0] {
        IMM_R = 3'd0,
        IMM_I = 3'd1,
        IMM_S = 3'd2,
        IMM_B = 3'd3,
        IMM_U = 3'd4,
        IMM_J = 3'd5
    } imm_type_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] imm;
        imm_type_e   imm_type;
        logic        illegal;
    } entry_t;

endpackage

// File: rtl/decode_issue_ctrl_imm_gen.sv
// -----------------------------------------------------------------------------
// imm_gen
// Purely combinational opcode classifier and immediate generator.
// Ports:
//   inst     in  32  raw instruction
//   imm      out 32  sign-extended immediate for the detected format
//   imm_type out 3   R=0 I=1 S=2 B=3 U=4 J=5
//   illegal  out 1   opcode outside the legal set or inst[1:0] != 2'b11
// Illegal instructions report format J with the J-type immediate.
// -----------------------------------------------------------------------------
module imm_gen
    import decode_pkg::*;
(
    input  logic [31:0] inst,
    output logic [31:0] imm,
    output logic [2:0]  imm_type,
    output logic        illegal
);

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    imm_type_e   fmt;

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        fmt     = IMM_J;
        illegal = 1'b0;
        if (inst[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (inst[6:2])
                OPC_OP:                                    fmt = IMM_R;
                OPC_OP_IMM, OPC_LOAD, OPC_JALR,
                OPC_MISC_MEM, OPC_SYSTEM:                  fmt = IMM_I;
                OPC_STORE:                                 fmt = IMM_S;
                OPC_BRANCH:                                fmt = IMM_B;
                OPC_LUI, OPC_AUIPC:                        fmt = IMM_U;
                OPC_JAL:                                   fmt = IMM_J;
                default:                                   illegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        imm = '0;
        case (fmt)
            IMM_R:   imm = '0;
            IMM_I:   imm = imm_i;
            IMM_S:   imm = imm_s;
            IMM_B:   imm = imm_b;
            IMM_U:   imm = imm_u;
            default: imm = imm_j;
        endcase
    end

    assign imm_type = fmt;

endmodule

// File: rtl/decode_issue_ctrl.sv
// -----------------------------------------------------------------------------
// decode_issue_ctrl
// Decode-stage controller: accepts instructions from fetch (valid/ready),
// decodes the immediate format through imm_gen, and buffers decoded entries
// in a DEPTH-entry FIFO toward execute. Supports flush.
// Ports:
//   clk, rst_n (sync, active low), flush
//   in_valid/in_ready/in_inst/in_pc         fetch side
//   out_valid/out_ready/out_inst/out_pc/
//   out_imm/out_imm_type/out_illegal        execute side (data 0 when empty)
//   halted                                  trap state active
// Parameters: DEPTH (2..8), XLEN (fixed 32).
// Optional feature: `define DECODE_ILLEGAL_TRAP_EN makes an accepted illegal
// instruction move the controller to TRAP (in_ready=0) until flush/reset.
// -----------------------------------------------------------------------------
module decode_issue_ctrl
    import decode_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_imm_type,
    output logic            out_illegal,
    output logic            halted
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    state_e           state;
    state_e           state_nxt;

    logic [31:0]      dec_imm;
    logic [2:0]       dec_type;
    logic             dec_illegal;
    logic             accept;
    logic             pop;
    entry_t           head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    imm_gen u_imm_gen (
        .inst     (in_inst),
        .imm      (dec_imm),
        .imm_type (dec_type),
        .illegal  (dec_illegal)
    );

    // in_ready depends only on registered state, never on out_ready.
    assign in_ready  = (count < CNT_W'(DEPTH)) && (state == ST_RUN);
    assign out_valid = (count != '0);
    assign accept    = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_RUN;
`ifdef DECODE_ILLEGAL_TRAP_EN
        end else if (accept && dec_illegal) begin
            state_nxt = ST_TRAP;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    assign halted = (state == ST_TRAP);
`else
    assign halted = 1'b0;
`endif

    // FIFO storage; no reset needed, pointers/count define validity.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= '{inst:     in_inst,
                             pc:       in_pc,
                             imm:      dec_imm,
                             imm_type: imm_type_e'(dec_type),
                             illegal:  dec_illegal};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Data outputs are forced to zero while the FIFO is empty.
    always_comb begin
        head         = mem[rd_ptr];
        out_inst     = '0;
        out_pc       = '0;
        out_imm      = '0;
        out_imm_type = '0;
        out_illegal  = 1'b0;
        if (out_valid) begin
            out_inst     = head.inst;
            out_pc       = head.pc;
            out_imm      = head.imm;
            out_imm_type = head.imm_type;
            out_illegal  = head.illegal;
        end
    end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
module tb_decode_issue_ctrl;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_inst, in_pc;
    logic        in_ready, out_valid, out_illegal, halted;
    logic [31:0] out_inst, out_pc, out_imm;
    logic [2:0]  out_imm_type;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    decode_issue_ctrl #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_inst      (in_inst),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_inst     (out_inst),
        .out_pc       (out_pc),
        .out_imm      (out_imm),
        .out_imm_type (out_imm_type),
        .out_illegal  (out_illegal),
        .halted       (halted)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] imm;
        int          t;
        bit          ill;
    } ment_t;

    ment_t q[$];
    bit    m_trap = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode from the format rules using shifts/masks.
    function automatic void ref_decode(input logic [31:0] i, output logic [31:0] imm,
                                       output int t, output bit ill);
        logic [31:0] sx;
        sx  = i[31] ? 32'hFFFF_FFFF : 32'h0;
        ill = 1'b0;
        t   = 5;
        if (i[1:0] != 2'b11) begin
            ill = 1'b1;
        end else begin
            case (i[6:2])
                5'b01100:                                         t = 0;
                5'b00100, 5'b00000, 5'b11001, 5'b00011, 5'b11100: t = 1;
                5'b01000:                                         t = 2;
                5'b11000:                                         t = 3;
                5'b01101, 5'b00101:                               t = 4;
                5'b11011:                                         t = 5;
                default:                                          ill = 1'b1;
            endcase
        end
        case (t)
            0: imm = 32'h0;
            1: imm = (sx << 12) | (i >> 20);
            2: imm = (sx << 12) | ((i >> 25) << 5) | ((i >> 7) & 32'h1F);
            3: imm = (sx << 12) | (((i >> 7) & 32'h1) << 11) | (((i >> 25) & 32'h3F) << 5)
                     | (((i >> 8) & 32'hF) << 1);
            4: imm = i & 32'hFFFF_F000;
            default: imm = (sx << 20) | (i & 32'h000F_F000) | (((i >> 20) & 32'h1) << 11)
                           | (((i >> 21) & 32'h3FF) << 1);
        endcase
    endfunction

    // Behavioural model: a queue of decoded entries plus a trap flag.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n || flush) begin
                q.delete();
                m_trap = 1'b0;
            end else begin
                bit    acc;
                ment_t e;
                acc = in_valid && (q.size() < DEPTH) && !m_trap;
                if (out_ready && q.size() > 0) void'(q.pop_front());
                if (acc) begin
                    e.inst = in_inst;
                    e.pc   = in_pc;
                    ref_decode(in_inst, e.imm, e.t, e.ill);
                    q.push_back(e);
`ifdef DECODE_ILLEGAL_TRAP_EN
                    if (e.ill) m_trap = 1'b1;
`endif
                end
            end
        end
    end

    // Compare DUT against model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", 32'(out_valid), 32'(q.size() > 0));
            check("in_ready", 32'(in_ready), 32'((q.size() < DEPTH) && !m_trap));
            check("halted", 32'(halted), 32'(m_trap));
            if (q.size() > 0) begin
                check("out_inst", out_inst, q[0].inst);
                check("out_pc", out_pc, q[0].pc);
                check("out_imm", out_imm, q[0].imm);
                check("out_imm_type", 32'(out_imm_type), 32'(q[0].t));
                check("out_illegal", 32'(out_illegal), 32'(q[0].ill));
            end else begin
                check("out_inst_empty", out_inst, 32'h0);
                check("out_pc_empty", out_pc, 32'h0);
                check("out_imm_empty", out_imm, 32'h0);
                check("out_type_empty", 32'(out_imm_type), 32'h0);
                check("out_illegal_empty", 32'(out_illegal), 32'h0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] t2_inst [3] = '{32'hFE11_2E23, 32'h1234_52B7, 32'h0010_00EF};
    logic [31:0] t2_imm  [3] = '{32'hFFFF_FFFC, 32'h1234_5000, 32'h0000_0800};
    logic [31:0] t2_type [3] = '{32'd2, 32'd4, 32'd5};
    logic [4:0]  ops [11] = '{5'b00000, 5'b01000, 5'b11000, 5'b11001, 5'b11011, 5'b00100,
                              5'b01100, 5'b00101, 5'b01101, 5'b00011, 5'b11100};

    initial begin
        logic [31:0] exp_pc [3];
        logic [31:0] r;
        int          got;
        bit          will_acc;
        int          k;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0;
        tick();
        tick();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_out_illegal", 32'(out_illegal), 32'h0);
        check("rst_out_inst", out_inst, 32'h0);

        // addi x1,x0,-1
        in_valid = 1'b1; in_inst = 32'hFFF0_0093; in_pc = 32'h1000; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("addi_valid", 32'(out_valid), 32'h1);
        check("addi_imm", out_imm, 32'hFFFF_FFFF);
        check("addi_type", 32'(out_imm_type), 32'h1);
        check("addi_illegal", 32'(out_illegal), 32'h0);
        check("addi_pc", out_pc, 32'h1000);
        check("model_addi_imm", (q.size() > 0) ? q[0].imm : 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        tick();
        check("addi_drained", 32'(out_valid), 32'h0);

        // Back-to-back sw, lui, jal with execute always ready
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_inst = t2_inst[i]; in_pc = 32'h1100 + 32'(4 * i);
            tick();
            check("b2b_inst", out_inst, t2_inst[i]);
            check("b2b_imm", out_imm, t2_imm[i]);
            check("b2b_type", 32'(out_imm_type), t2_type[i]);
            check("model_b2b_imm", (q.size() > 0) ? q[0].imm : 32'hDEAD_BEEF, t2_imm[i]);
        end
        in_valid = 1'b0;
        tick();
        check("b2b_drained", 32'(out_valid), 32'h0);

        // Backpressure: three offers, DEPTH=2
        out_ready = 1'b0;
        exp_pc = '{32'h2000, 32'h2004, 32'h2008};
        in_valid = 1'b1; in_inst = 32'hFFF0_0093; in_pc = exp_pc[0];
        tick();
        check("bp_ready_1", 32'(in_ready), 32'h1);
        in_pc = exp_pc[1];
        tick();
        check("bp_ready_full", 32'(in_ready), 32'h0);
        in_pc = exp_pc[2];
        tick();
        check("bp_still_full", 32'(in_ready), 32'h0);
        check("bp_head_pc", out_pc, exp_pc[0]);
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            if (out_valid) begin
                check("bp_order_pc", out_pc, exp_pc[got]);
                got++;
            end
            will_acc = in_valid && in_ready;
            tick();
            if (will_acc) in_valid = 1'b0;
        end
        check("bp_drain_count", 32'(got), 32'd3);
        check("bp_empty", 32'(out_valid), 32'h0);

        // Flush with two buffered entries and a same-cycle offer
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'h3000;
        tick();
        in_pc = 32'h3004;
        tick();
        check("fl_full_valid", 32'(out_valid), 32'h1);
        in_pc = 32'h3008; flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_out_valid", 32'(out_valid), 32'h0);
        check("fl_in_ready", 32'(in_ready), 32'h1);
        tick();
        check("fl_not_enqueued", 32'(out_valid), 32'h0);

        // Illegal instruction 0x00000000
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h0; in_pc = 32'h4000;
        tick();
        in_valid = 1'b0;
        check("ill_flag", 32'(out_illegal), 32'h1);
        check("ill_type", 32'(out_imm_type), 32'd5);
        check("ill_imm", out_imm, 32'h0);
`ifdef DECODE_ILLEGAL_TRAP_EN
        check("trap_halted", 32'(halted), 32'h1);
        check("trap_in_ready", 32'(in_ready), 32'h0);
        in_valid = 1'b1; in_inst = 32'hFFF0_0093; in_pc = 32'h4004;
        tick();
        in_valid = 1'b0;
        check("trap_hold_ready", 32'(in_ready), 32'h0);
        check("trap_head_pc", out_pc, 32'h4000);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("trap_flush_halted", 32'(halted), 32'h0);
        check("trap_flush_ready", 32'(in_ready), 32'h1);
        check("trap_flush_valid", 32'(out_valid), 32'h0);
`else
        check("notrap_halted", 32'(halted), 32'h0);
        check("notrap_in_ready", 32'(in_ready), 32'h1);
        in_valid = 1'b1; in_inst = 32'hFFF0_0093; in_pc = 32'h4004;
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        check("notrap_head_pc", out_pc, 32'h4000);
        tick();
        check("notrap_next_pc", out_pc, 32'h4004);
        check("notrap_next_type", 32'(out_imm_type), 32'h1);
        check("notrap_next_legal", 32'(out_illegal), 32'h0);
        tick();
`endif

        // Reset with two buffered entries
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h1234_52B7; in_pc = 32'h5000;
        tick();
        in_pc = 32'h5004;
        tick();
        in_valid = 1'b0;
        check("rs_full", 32'(out_valid), 32'h1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rs_out_valid", 32'(out_valid), 32'h0);
        check("rs_in_ready", 32'(in_ready), 32'h1);
        check("rs_halted", 32'(halted), 32'h0);

        // Randomized traffic checked by the compare process
        for (int n = 0; n < 3000; n++) begin
            r = $urandom;
            k = $urandom_range(0, 12);
            if (k < 11) in_inst = {r[31:7], ops[k], 2'b11};
            else        in_inst = r;
            in_pc     = $urandom;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            rst_n     = ($urandom_range(0, 99) != 0);
            tick();
        end
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
